multi_bin_threshold_trig: RTL and testbench
===========================================

Name: multi_bin_threshold_trig

Overview:
Parametrised successor to the 40 MHz single bin trigger in the SDE trigger block. Compares NCHAN PMT ADC streams against per-channel thresholds and applies a channel multiplicity requirement. Adds a consecutive-bin (time-over-threshold) qualification, a holdoff, a one-trigger-per-excursion rearm state machine and a trigger counter. Runs either at the full 120 MHz sample rate or in 40 MHz compatibility mode.

Parameters:
NCHAN, 3, number of PMT channels (1..7)
ADC_WIDTH, 12, ADC sample and threshold width
CW, $clog2(NCHAN+1), width of MULTIPLICITY and internal channel sum (derived; do not override)

Ports:
CLK120  input  1  120 MHz system clock; the only clock
RESET  input  1  synchronous, active-high reset
MODE40  input  1  1 = 40 MHz compatibility (advance only on phase ticks); 0 = every CLK120 cycle
ENABLE40  input  2  40 MHz phase counter; tick when ENABLE40==0
ADC  input  NCHAN*ADC_WIDTH  packed samples, channel i at [i*ADC_WIDTH +: ADC_WIDTH]
THRES  input  NCHAN*ADC_WIDTH  packed thresholds, same packing
TRIG_ENABLE  input  NCHAN  per-channel enable
MULTIPLICITY  input  CW  required number of channels over threshold; 0 disables
NBINS  input  4  consecutive qualifying samples required; 0 treated as 1
HOLDOFF  input  8  sample ticks of dead time after a trigger
TRIG  output  1  one-CLK120-cycle trigger pulse
PMT_TRIG  output  NCHAN  registered per-channel over-threshold flags
TRIG_COUNT  output  16  saturating count of TRIG pulses

Behaviour:
- Interface: one clock, CLK120. RESET is synchronous and active-high.
- Sample tick STB = MODE40 ? (ENABLE40==0) : 1. All pipeline registers, the run counter and the holdoff counter advance only when STB=1. The FSM and TRIG are evaluated every CLK120 cycle.
- Pipeline, one stage per STB:
  - S1: register ADC and THRES.
  - S2: PMT_TRIG[i] = (ADC_i > THRES_i), strictly greater, AND TRIG_ENABLE[i].
  - S3: SUM = popcount(PMT_TRIG), CW bits, no overflow possible.
  - S4: ITRIG = (SUM >= MULTIPLICITY) && (MULTIPLICITY != 0). MULTIPLICITY > NCHAN never triggers.
- Run counter RUN (4 bits): on STB, if ITRIG then RUN = min(RUN+1, 15), else RUN = 0. QUAL = (RUN >= max(NBINS,1)).
- FSM states and transitions:
  - IDLE: QUAL -> FIRE.
  - FIRE: TRIG=1 for exactly one CLK120 cycle; load HCNT=HOLDOFF. Go to HOLD if HOLDOFF!=0, else to REARM.
  - HOLD: decrement HCNT on each STB; when HCNT reaches 0 -> REARM. QUAL is ignored in HOLD.
  - REARM: wait for QUAL=0, then -> IDLE. A continuous excursion yields exactly one TRIG.
- Latency, MODE40=0, NBINS=1: TRIG is high in the cycle after the 5th rising CLK120 edge following ADC presentation (S1..S4, RUN, FSM). In MODE40=1 the pipeline steps once per tick, and TRIG is still a single CLK120 cycle wide.
- Configuration inputs (THRES, TRIG_ENABLE, MULTIPLICITY, NBINS, HOLDOFF, MODE40) are used live. A change mid-excursion takes effect on the next STB and never produces a multi-cycle TRIG.
- TRIG_COUNT increments on each TRIG and holds at 16'hFFFF.
- RESET clears all pipeline registers, RUN, HCNT, TRIG=0, PMT_TRIG=0 and TRIG_COUNT=0, and sets the FSM to IDLE. This applies in any state, including mid-HOLD; the first post-reset trigger needs fresh samples to fill the pipeline.
- RESET wins over every other event in the same cycle.

Test Plan:
1. NCHAN=3, MODE40=0, THRES=100 on all channels, MULT=2, NBINS=1, HOLDOFF=0; ch0 and ch1 = 101 for one cycle -> one TRIG pulse 5 cycles later, TRIG_COUNT=1. Repeat with ADC=100 -> no TRIG (strict compare).
2. NBINS=3, two channels over threshold for 2 samples, then below -> no TRIG. Over threshold for 3 samples -> exactly one TRIG. Held over threshold for 50 samples -> still one TRIG (REARM).
3. HOLDOFF=10, bursts of 1 qualifying sample spaced 6 samples apart -> 2nd burst ignored; a burst 14 samples after the first triggers (REARM passed); TRIG_COUNT=2.
4. MODE40=1, ENABLE40 cycling 0,1,2, ADC changing every cycle -> only phase-0 samples affect PMT_TRIG; TRIG is 1 CLK120 cycle wide.
5. MULTIPLICITY=0 with all channels over threshold -> no TRIG. MULTIPLICITY=3 with TRIG_ENABLE=3'b011 -> no TRIG.
6. Assert RESET during HOLD with TRIG_COUNT=5 -> TRIG=0 and TRIG_COUNT=0 next cycle, FSM in IDLE. Preload the counter near 16'hFFFF and keep firing -> count saturates at 16'hFFFF.

Source files
------------

// File: rtl/multi_bin_threshold_trig_if.sv
// Signal bundle between the trigger block and its ADC/configuration source.
// Channel i of ADC and THRES sits at [i*ADC_WIDTH +: ADC_WIDTH].
interface multi_bin_threshold_trig_if #(
  parameter int NCHAN     = 3,
  parameter int ADC_WIDTH = 12
);
  localparam int CW = $clog2(NCHAN + 1);

  logic                       MODE40;
  logic [1:0]                 ENABLE40;
  logic [NCHAN*ADC_WIDTH-1:0] ADC;
  logic [NCHAN*ADC_WIDTH-1:0] THRES;
  logic [NCHAN-1:0]           TRIG_ENABLE;
  logic [CW-1:0]              MULTIPLICITY;
  logic [3:0]                 NBINS;
  logic [7:0]                 HOLDOFF;
  logic                       TRIG;
  logic [NCHAN-1:0]           PMT_TRIG;
  logic [15:0]                TRIG_COUNT;

  modport master (
    output MODE40, ENABLE40, ADC, THRES, TRIG_ENABLE, MULTIPLICITY, NBINS, HOLDOFF,
    input  TRIG, PMT_TRIG, TRIG_COUNT
  );

  modport slave (
    input  MODE40, ENABLE40, ADC, THRES, TRIG_ENABLE, MULTIPLICITY, NBINS, HOLDOFF,
    output TRIG, PMT_TRIG, TRIG_COUNT
  );
endinterface

// File: rtl/multi_bin_threshold_trig.sv
// Multi-channel threshold trigger with multiplicity, time-over-threshold
// qualification, holdoff and one-trigger-per-excursion rearm.
module multi_bin_threshold_trig #(
  parameter int NCHAN     = 3,
  parameter int ADC_WIDTH = 12
) (
  input logic                  CLK120,
  input logic                  RESET,
  multi_bin_threshold_trig_if.slave bus
);
  localparam int CW = $clog2(NCHAN + 1);

  typedef enum logic [1:0] {IDLE, FIRE, HOLD, REARM} state_t;

  logic                       stb;
  logic [NCHAN*ADC_WIDTH-1:0] adc_q;
  logic [NCHAN*ADC_WIDTH-1:0] thres_q;
  logic [NCHAN-1:0]           over;
  logic [NCHAN-1:0]           pmt_q;
  logic [CW-1:0]              pop;
  logic [CW-1:0]              sum_q;
  logic                       itrig;
  logic [3:0]                 run_q;
  logic [3:0]                 nbins_eff;
  logic                       qual;
  logic [7:0]                 hcnt_q;
  logic [7:0]                 hcnt_d;
  logic [15:0]                count_q;
  logic                       trig;
  state_t                     state_q;
  state_t                     state_d;

  assign stb = bus.MODE40 ? (bus.ENABLE40 == 2'd0) : 1'b1;

  always_comb begin
    over = '0;
    for (int i = 0; i < NCHAN; i++) begin
      over[i] = (adc_q[i*ADC_WIDTH +: ADC_WIDTH] > thres_q[i*ADC_WIDTH +: ADC_WIDTH])
                && bus.TRIG_ENABLE[i];
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NCHAN; i++) begin
      pop = pop + CW'(pmt_q[i]);
    end
  end

  // The multiplicity decision is combinational on the registered sum so that
  // the run counter is the fourth registered stage after the ADC capture.
  assign itrig     = (sum_q >= bus.MULTIPLICITY) && (bus.MULTIPLICITY != '0);
  assign nbins_eff = (bus.NBINS == 4'd0) ? 4'd1 : bus.NBINS;
  assign qual      = (run_q >= nbins_eff);

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      adc_q   <= '0;
      thres_q <= '0;
      pmt_q   <= '0;
      sum_q   <= '0;
      run_q   <= '0;
    end else if (stb) begin
      adc_q   <= bus.ADC;
      thres_q <= bus.THRES;
      pmt_q   <= over;
      sum_q   <= pop;
      if (itrig) begin
        run_q <= (run_q == 4'd15) ? 4'd15 : run_q + 4'd1;
      end else begin
        run_q <= '0;
      end
    end
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      if ((state_q == FIRE) && (count_q != 16'hFFFF)) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  // FIRE is left after one CLK120 cycle regardless of the sample tick, so the
  // pulse stays one system cycle wide in 40 MHz mode too.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    trig    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (qual) state_d = FIRE;
      end
      FIRE: begin
        trig    = 1'b1;
        hcnt_d  = bus.HOLDOFF;
        state_d = (bus.HOLDOFF != 8'd0) ? HOLD : REARM;
      end
      HOLD: begin
        if (stb) begin
          hcnt_d = hcnt_q - 8'd1;
          if (hcnt_q <= 8'd1) state_d = REARM;
        end
      end
      REARM: begin
        if (!qual) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.TRIG       = trig;
  assign bus.PMT_TRIG   = pmt_q;
  assign bus.TRIG_COUNT = count_q;

endmodule

// File: tb/tb_multi_bin_threshold_trig.sv
// Directed and randomized checks of multi_bin_threshold_trig against a
// tick-level reference model of the trigger rules.
module tb_multi_bin_threshold_trig;
  localparam int NCHAN = 3;
  localparam int W     = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_bin_threshold_trig_if #(.NCHAN(NCHAN), .ADC_WIDTH(W)) bus ();

  multi_bin_threshold_trig #(.NCHAN(NCHAN), .ADC_WIDTH(W)) dut (
    .CLK120(clk),
    .RESET (rst),
    .bus   (bus)
  );

  int adc_v[NCHAN];
  int thr_v[NCHAN];
  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int trig_seen = 0;
  int trig_cyc  = -1;
  int c0        = 0;
  bit prev_trig = 1'b0;

  // Reference model state: sample history per tick plus trigger bookkeeping.
  logic [NCHAN-1:0] q_over[$];
  bit               q_hit[$];
  int               m_run   = 0;
  int               m_hold  = 0;
  int               m_count = 0;
  bit               m_wait  = 1'b0;
  bit               m_trig  = 1'b0;
  logic [NCHAN-1:0] m_pmt   = '0;

  function automatic logic [NCHAN-1:0] over_now();
    logic [NCHAN-1:0] v;
    v = '0;
    for (int i = 0; i < NCHAN; i++) v[i] = bus.TRIG_ENABLE[i] && (adc_v[i] > thr_v[i]);
    return v;
  endfunction

  function automatic int popc(logic [NCHAN-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NCHAN; i++) n += int'(v[i]);
    return n;
  endfunction

  always @(posedge clk) begin : ref_model
    bit               stb;
    bit               qual;
    bit               fire;
    int               nb;
    logic [NCHAN-1:0] ov;
    stb  = !bus.MODE40 || (bus.ENABLE40 == 2'd0);
    nb   = (bus.NBINS == 4'd0) ? 1 : int'(bus.NBINS);
    qual = (m_run >= nb);
    if (rst) begin
      q_over.delete();
      q_hit.delete();
      m_run = 0; m_hold = 0; m_count = 0; m_wait = 0; m_trig = 0; m_pmt = '0;
    end else begin
      fire = 1'b0;
      if (m_trig) begin
        m_count = (m_count < 65535) ? m_count + 1 : 65535;
        if (bus.HOLDOFF != 8'd0) m_hold = int'(bus.HOLDOFF);
        else m_wait = 1'b1;
      end else if (m_hold > 0) begin
        if (stb) begin
          m_hold--;
          if (m_hold == 0) m_wait = 1'b1;
        end
      end else if (m_wait) begin
        if (!qual) m_wait = 1'b0;
      end else if (qual) begin
        fire = 1'b1;
      end
      m_trig = fire;
      if (stb) begin
        ov = over_now();
        q_over.push_front(ov);
        q_hit.push_front((popc(ov) >= int'(bus.MULTIPLICITY)) && (bus.MULTIPLICITY != '0));
        m_pmt = (q_over.size() > 1) ? q_over[1] : '0;
        if (q_hit.size() > 3) m_run = q_hit[3] ? ((m_run < 15) ? m_run + 1 : 15) : 0;
        else m_run = 0;
        if (q_over.size() > 4) begin
          void'(q_over.pop_back());
          void'(q_hit.pop_back());
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("trig", 32'(bus.TRIG), 32'(m_trig));
    check("pmt_trig", 32'(bus.PMT_TRIG), 32'(m_pmt));
    check("trig_count", 32'(bus.TRIG_COUNT), 32'(m_count));
    check("trig_width", 32'(bus.TRIG & prev_trig), 32'd0);
    prev_trig = bus.TRIG;
    if (bus.TRIG === 1'b1) begin
      trig_seen++;
      trig_cyc = cyc;
    end
  endtask

  task automatic drive_thres();
    for (int i = 0; i < NCHAN; i++) bus.THRES[i*W +: W] = W'(thr_v[i]);
  endtask

  // One CLK120 cycle: check the state left by the last edge, then drive the next sample.
  task automatic apply_stimulus(input int a0, input int a1, input int a2);
    @(negedge clk);
    cyc++;
    check_output();
    adc_v[0] = a0; adc_v[1] = a1; adc_v[2] = a2;
    for (int i = 0; i < NCHAN; i++) bus.ADC[i*W +: W] = W'(adc_v[i]);
    bus.ENABLE40 = 2'(cyc % 3);
  endtask

  task automatic hold_cycles(input int v, input int n);
    repeat (n) apply_stimulus(v, v, v);
  endtask

  task automatic set_config(input int thr, input logic [2:0] en, input int mult,
                            input int nbins, input int holdoff, input bit mode40);
    for (int i = 0; i < NCHAN; i++) thr_v[i] = thr;
    drive_thres();
    bus.TRIG_ENABLE  = en;
    bus.MULTIPLICITY = 2'(mult);
    bus.NBINS        = 4'(nbins);
    bus.HOLDOFF      = 8'(holdoff);
    bus.MODE40       = mode40;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold_cycles(0, 2);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCHAN; i++) adc_v[i] = 0;
    bus.ADC = '0;
    bus.ENABLE40 = 2'd0;
    set_config(100, 3'b111, 2, 1, 0, 1'b0);
    rst = 1'b1;
    hold_cycles(0, 3);
    rst = 1'b0;
    hold_cycles(0, 1);
    check("reset_trig", 32'(bus.TRIG), 32'd0);
    check("reset_pmt", 32'(bus.PMT_TRIG), 32'd0);
    check("reset_count", 32'(bus.TRIG_COUNT), 32'd0);

    // Single-cycle excursion on two channels, then the equal-to-threshold case.
    hold_cycles(0, 4);
    trig_seen = 0;
    apply_stimulus(101, 101, 0);
    c0 = cyc;
    hold_cycles(0, 10);
    check("t1_trigs", 32'(trig_seen), 32'd1);
    check("t1_latency", 32'(trig_cyc - c0), 32'd5);
    check("t1_count", 32'(bus.TRIG_COUNT), 32'd1);
    trig_seen = 0;
    apply_stimulus(100, 100, 100);
    hold_cycles(0, 10);
    check("t1_strict", 32'(trig_seen), 32'd0);

    // Time-over-threshold with NBINS=3.
    set_config(100, 3'b111, 2, 3, 0, 1'b0);
    trig_seen = 0;
    repeat (2) apply_stimulus(101, 101, 0);
    hold_cycles(0, 10);
    check("t2_short", 32'(trig_seen), 32'd0);
    repeat (3) apply_stimulus(101, 101, 0);
    hold_cycles(0, 10);
    check("t2_three", 32'(trig_seen), 32'd1);
    trig_seen = 0;
    repeat (50) apply_stimulus(101, 0, 101);
    hold_cycles(0, 10);
    check("t2_long", 32'(trig_seen), 32'd1);

    // Holdoff of 10 ticks: burst at +6 is dead time, burst at +14 is accepted.
    do_reset();
    set_config(100, 3'b111, 2, 1, 10, 1'b0);
    hold_cycles(0, 4);
    trig_seen = 0;
    apply_stimulus(101, 101, 0);
    hold_cycles(0, 5);
    apply_stimulus(101, 101, 0);
    hold_cycles(0, 7);
    apply_stimulus(101, 101, 0);
    hold_cycles(0, 30);
    check("t3_trigs", 32'(trig_seen), 32'd2);
    check("t3_count", 32'(bus.TRIG_COUNT), 32'd2);

    // 40 MHz compatibility mode.
    set_config(100, 3'b111, 2, 1, 0, 1'b1);
    hold_cycles(0, 12);
    for (int k = 0; k < 60; k++)
      apply_stimulus(98 + $urandom_range(0, 5), 98 + $urandom_range(0, 5), 98 + $urandom_range(0, 5));
    hold_cycles(0, 30);
    trig_seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (((cyc + 1) % 3) != 0) apply_stimulus(150, 150, 150);
      else apply_stimulus(0, 0, 0);
    end
    hold_cycles(0, 30);
    check("t4_offphase", 32'(trig_seen), 32'd0);
    while (((cyc + 1) % 3) != 0) apply_stimulus(0, 0, 0);
    apply_stimulus(150, 150, 0);
    hold_cycles(0, 30);
    check("t4_phase0", 32'(trig_seen), 32'd1);

    // Multiplicity disabled, and multiplicity above the enabled channel count.
    set_config(100, 3'b111, 0, 1, 0, 1'b0);
    hold_cycles(0, 12);
    trig_seen = 0;
    hold_cycles(200, 15);
    hold_cycles(0, 12);
    check("t5_mult0", 32'(trig_seen), 32'd0);
    set_config(100, 3'b011, 3, 1, 0, 1'b0);
    hold_cycles(200, 15);
    hold_cycles(0, 12);
    check("t5_mult3", 32'(trig_seen), 32'd0);

    // Reset mid-HOLD, then counter saturation.
    do_reset();
    set_config(100, 3'b111, 2, 1, 3, 1'b0);
    hold_cycles(0, 4);
    trig_seen = 0;
    repeat (4) begin
      apply_stimulus(101, 101, 0);
      hold_cycles(0, 11);
    end
    bus.HOLDOFF = 8'd100;
    apply_stimulus(101, 101, 0);
    hold_cycles(0, 15);
    check("t6_pre_count", 32'(bus.TRIG_COUNT), 32'd5);
    check("t6_pre_trigs", 32'(trig_seen), 32'd5);
    rst = 1'b1;
    apply_stimulus(0, 0, 0);
    rst = 1'b0;
    apply_stimulus(0, 0, 0);
    check("t6_rst_trig", 32'(bus.TRIG), 32'd0);
    check("t6_rst_count", 32'(bus.TRIG_COUNT), 32'd0);
    bus.HOLDOFF = 8'd0;
    hold_cycles(0, 3);
    trig_seen = 0;
    apply_stimulus(101, 101, 0);
    c0 = cyc;
    hold_cycles(0, 10);
    check("t6_post_trigs", 32'(trig_seen), 32'd1);
    check("t6_post_latency", 32'(trig_cyc - c0), 32'd5);
    @(negedge clk);
    force dut.count_q = 16'hFFFC;
    m_count = 65532;
    apply_stimulus(0, 0, 0);
    release dut.count_q;
    trig_seen = 0;
    repeat (6) begin
      apply_stimulus(101, 101, 0);
      hold_cycles(0, 8);
    end
    hold_cycles(0, 4);
    check("t6_sat_trigs", 32'(trig_seen), 32'd6);
    check("t6_sat", 32'(bus.TRIG_COUNT), 32'hFFFF);

    // Randomized configurations and samples around threshold.
    for (int r = 0; r < 8; r++) begin
      hold_cycles(0, 100);
      for (int i = 0; i < NCHAN; i++) thr_v[i] = $urandom_range(50, 200);
      drive_thres();
      bus.TRIG_ENABLE  = 3'($urandom_range(0, 7));
      bus.MULTIPLICITY = 2'($urandom_range(0, 3));
      bus.NBINS        = 4'($urandom_range(0, 4));
      bus.HOLDOFF      = 8'($urandom_range(0, 15));
      bus.MODE40       = 1'($urandom_range(0, 1));
      for (int k = 0; k < 80; k++)
        apply_stimulus(thr_v[0] - 1 + $urandom_range(0, 3),
                       thr_v[1] - 1 + $urandom_range(0, 3),
                       thr_v[2] - 1 + $urandom_range(0, 3));
    end
    hold_cycles(0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
